// File: rtl/mem_bank_be_if.sv
// Request/response bundle for mem_bank_be: write and read request ports,
// read response, and the clear-engine control/status pair.
interface mem_bank_be_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int NBYTES = DATA_WIDTH / 8;

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_be;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  clear_start;
    logic                  init_busy;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        output rd_valid, rd_addr, clear_start,
        input  req_ready, rsp_valid, rsp_rdata, init_busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        input  rd_valid, rd_addr, clear_start,
        output req_ready, rsp_valid, rsp_rdata, init_busy
    );
endinterface

// File: rtl/mem_bank_be.sv
// Byte-enable scratch memory with separate write/read request ports, a
// configurable-latency read pipeline and a sequential clear engine.
module mem_bank_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic            clk,
    input  logic            reset,
    mem_bank_be_if.slave    bus
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  busy;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  vld_q   [RD_LATENCY];
    logic                  vld_d   [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pdata_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pdata_d [RD_LATENCY];

    always_comb begin
        busy        = (state_q == ST_CLEAR);
        wr_acc      = bus.wr_valid && !busy;
        rd_acc      = bus.rd_valid && !busy;
        merged_word = merge_bytes(mem_q[bus.wr_addr], bus.wr_data, bus.wr_be);

        // Write-first forwards the merged word only on a true same-address collision
        rd_word = mem_q[bus.rd_addr];
        if (RDW_MODE == 1 && wr_acc && (bus.wr_addr == bus.rd_addr)) begin
            rd_word = merged_word;
        end

        mem_we    = 1'b0;
        mem_idx   = bus.wr_addr;
        mem_wdata = merged_word;
        if (!reset) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_idx   = clr_cnt_q;
                mem_wdata = '0;
            end else if (wr_acc) begin
                mem_we = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (&clr_cnt_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    // Read pipeline: data stages load only with a valid, so the last stage holds
    always_comb begin
        vld_d[0]   = rd_acc;
        pdata_d[0] = rd_acc ? rd_word : pdata_q[0];
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            pdata_d[i] = vld_q[i-1] ? pdata_q[i-1] : pdata_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RD_LATENCY; i++) begin
            vld_q[i]   <= reset ? 1'b0 : vld_d[i];
            pdata_q[i] <= pdata_d[i];
        end
        if (reset) pdata_q[RD_LATENCY-1] <= '0;
    end

    assign bus.req_ready = !busy;
    assign bus.init_busy = busy;
    assign bus.rsp_valid = vld_q[RD_LATENCY-1];
    assign bus.rsp_rdata = pdata_q[RD_LATENCY-1];
endmodule

// File: tb/tb_mem_bank_be.sv
// Directed bench for mem_bank_be: four instances (latency 1/1/3/2, read-first and
// write-first) share one stimulus; responses are matched against expected queues.
module tb_mem_bank_be;
    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_valid;
    logic [3:0]  rd_addr;
    logic        clear_start;

    mem_bank_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) ifa ();
    mem_bank_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) ifb ();
    mem_bank_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) ifc ();
    mem_bank_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) ifd ();

    assign ifa.wr_valid = wr_valid;  assign ifb.wr_valid = wr_valid;
    assign ifc.wr_valid = wr_valid;  assign ifd.wr_valid = wr_valid;
    assign ifa.wr_addr = wr_addr;    assign ifb.wr_addr = wr_addr;
    assign ifc.wr_addr = wr_addr;    assign ifd.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data;    assign ifb.wr_data = wr_data;
    assign ifc.wr_data = wr_data;    assign ifd.wr_data = wr_data;
    assign ifa.wr_be = wr_be;        assign ifb.wr_be = wr_be;
    assign ifc.wr_be = wr_be;        assign ifd.wr_be = wr_be;
    assign ifa.rd_valid = rd_valid;  assign ifb.rd_valid = rd_valid;
    assign ifc.rd_valid = rd_valid;  assign ifd.rd_valid = rd_valid;
    assign ifa.rd_addr = rd_addr;    assign ifb.rd_addr = rd_addr;
    assign ifc.rd_addr = rd_addr;    assign ifd.rd_addr = rd_addr;
    assign ifa.clear_start = clear_start;  assign ifb.clear_start = clear_start;
    assign ifc.clear_start = clear_start;  assign ifd.clear_start = clear_start;

    mem_bank_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_LATENCY(1), .RDW_MODE(0))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mem_bank_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_LATENCY(1), .RDW_MODE(1))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    mem_bank_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_LATENCY(3), .RDW_MODE(0))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));
    mem_bank_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_LATENCY(2), .RDW_MODE(0))
        dut_d (.clk(clk), .reset(reset), .bus(ifd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  wbe;
        logic        rv;
        logic [3:0]  ra;
        logic [15:0] erf;
        logic [15:0] ewf;
    } vec_t;

    vec_t        vt[$];
    int          total;
    int          bad;
    int          cyc;
    int          lat [4];
    logic [15:0] ed  [4][64];
    int          edue[4][64];
    int          qh  [4];
    int          qt  [4];
    int          n;

    task automatic add(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] wbe, input logic rv, input logic [3:0] ra,
                       input logic [15:0] erf, input logic [15:0] ewf);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.wbe = wbe;
        v.rv = rv; v.ra = ra; v.erf = erf; v.ewf = ewf;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] d);
        ed[k][qt[k] % 64]   = d;
        edue[k][qt[k] % 64] = cyc + lat[k];
        qt[k]++;
    endtask

    task automatic push_all(input logic [15:0] rf, input logic [15:0] wf);
        for (int k = 0; k < 4; k++) push(k, (k == 1) ? wf : rf);
    endtask

    task automatic check_rsp(input int k, input logic v, input logic [15:0] d);
        if (v) begin
            total++;
            if (qh[k] == qt[k]) begin
                bad++;
                $display("FAIL rsp_unexpected dut%0d cyc=%0d got=%h expected no response", k, cyc, d);
            end else begin
                if (d !== ed[k][qh[k] % 64] || cyc != edue[k][qh[k] % 64]) begin
                    bad++;
                    $display("FAIL rsp_data dut%0d cyc=%0d got=%h expected=%h at cyc %0d",
                             k, cyc, d, ed[k][qh[k] % 64], edue[k][qh[k] % 64]);
                end
                qh[k]++;
            end
        end else if (qh[k] != qt[k] && edue[k][qh[k] % 64] <= cyc) begin
            total++;
            bad++;
            $display("FAIL rsp_missing dut%0d cyc=%0d got=none expected=%h", k, cyc, ed[k][qh[k] % 64]);
            qh[k]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_rsp(0, ifa.rsp_valid, ifa.rsp_rdata);
        check_rsp(1, ifb.rsp_valid, ifb.rsp_rdata);
        check_rsp(2, ifc.rsp_valid, ifc.rsp_rdata);
        check_rsp(3, ifd.rsp_valid, ifd.rsp_rdata);
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_valid = 1'b0; rd_addr = '0; clear_start = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        lat[0] = 1; lat[1] = 1; lat[2] = 3; lat[3] = 2;
        for (int k = 0; k < 4; k++) begin qh[k] = 0; qt[k] = 0; end

        for (int a = 0; a < 16; a++) add(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a), 16'h0000, 16'h0000);
        add(1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, 4'd0, 16'h0, 16'h0);
        add(1'b1, 4'd3, 16'h1200, 2'b10, 1'b0, 4'd0, 16'h0, 16'h0);
        add(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd3, 16'h12CD, 16'h12CD);
        add(1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 16'h0, 16'h0);
        add(1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5, 16'h1111, 16'h2222);
        add(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd5, 16'h2222, 16'h2222);
        add(1'b1, 4'd6, 16'h55AA, 2'b01, 1'b1, 4'd6, 16'h0000, 16'h00AA);
        add(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd6, 16'h00AA, 16'h00AA);
        add(1'b1, 4'd8, 16'hFFFF, 2'b00, 1'b0, 4'd0, 16'h0, 16'h0);
        add(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd8, 16'h0000, 16'h0000);
        add(1'b1, 4'd9, 16'h7777, 2'b11, 1'b1, 4'd3, 16'h12CD, 16'h12CD);
        add(1'b0, 4'd0, 16'h0,    2'b00, 1'b1, 4'd9, 16'h7777, 16'h7777);
        for (int a = 0; a < 4; a++) add(1'b1, 4'(a), 16'h00A0 + 16'(a), 2'b11, 1'b0, 4'd0, 16'h0, 16'h0);
        for (int a = 0; a < 4; a++) add(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a), 16'h00A0 + 16'(a), 16'h00A0 + 16'(a));

        // Reset and power-on clear
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        chk("reset_rsp_valid_a", 32'(ifa.rsp_valid), 32'd0);
        chk("reset_rdata_a",     32'(ifa.rsp_rdata), 32'h0);
        chk("reset_busy_a",      32'(ifa.init_busy), 32'd1);
        chk("reset_ready_a",     32'(ifa.req_ready), 32'd0);
        chk("reset_busy_c",      32'(ifc.init_busy), 32'd1);
        reset = 1'b0;
        n = 0;
        while (ifa.init_busy && n < 40) begin tick(); n++; end
        chk("init_len", 32'(n), 32'd16);
        chk("init_ready_d", 32'(ifd.req_ready), 32'd1);

        // Table-driven vectors
        foreach (vt[i]) begin
            chk("vec_ready", 32'(ifa.req_ready), 32'd1);
            wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].wbe;
            rd_valid = vt[i].rv; rd_addr = vt[i].ra;
            if (vt[i].rv) push_all(vt[i].erf, vt[i].ewf);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        // Clear requested alongside a read of live data
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF; wr_be = 2'b11;
        tick();
        idle_inputs();
        rd_valid = 1'b1; rd_addr = 4'd7; clear_start = 1'b1;
        push_all(16'hBEEF, 16'hBEEF);
        tick();
        clear_start = 1'b0;
        n = 0;
        while (ifa.init_busy && n < 40) begin
            chk("ready_in_clear", 32'(ifa.req_ready), 32'd0);
            clear_start = (n == 3);
            rd_valid = 1'b1; rd_addr = 4'd7;
            tick(); n++;
        end
        idle_inputs();
        chk("clear_len", 32'(n), 32'd16);
        rd_valid = 1'b1; rd_addr = 4'd7;
        push_all(16'h0000, 16'h0000);
        tick();
        idle_inputs();
        repeat (4) tick();

        // Reset drops in-flight reads and restarts an interrupted clear
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h5A5A; wr_be = 2'b11;
        tick();
        idle_inputs();
        rd_valid = 1'b1; rd_addr = 4'd3;
        push_all(16'h5A5A, 16'h5A5A);
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("rdata_hold_a", 32'(ifa.rsp_rdata), 32'h5A5A);
        chk("rdata_hold_d", 32'(ifd.rsp_rdata), 32'h5A5A);
        rd_valid = 1'b1; rd_addr = 4'd3;
        push(0, 16'h5A5A); push(1, 16'h5A5A);
        tick();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        chk("rst_drop_valid_d", 32'(ifd.rsp_valid), 32'd0);
        chk("rst_drop_rdata_d", 32'(ifd.rsp_rdata), 32'h0);
        chk("rst_drop_rdata_c", 32'(ifc.rsp_rdata), 32'h0);
        chk("rst_drop_rdata_a", 32'(ifa.rsp_rdata), 32'h0);
        reset = 1'b0;
        repeat (5) tick();
        chk("mid_clear_busy_d", 32'(ifd.init_busy), 32'd1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n = 0;
        while (ifd.init_busy && n < 40) begin tick(); n++; end
        chk("reclear_len", 32'(n), 32'd16);
        rd_valid = 1'b1; rd_addr = 4'd3;
        push_all(16'h0000, 16'h0000);
        tick();
        idle_inputs();
        repeat (5) tick();
        for (int k = 0; k < 4; k++) chk("pending_rsp", 32'(qt[k] - qh[k]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
